// File: rtl/tdm_mux64_tx.sv
// TDM transmitter: one parallel word in, one channel bit per clock out.
// Optional parity slot after each frame when TDM_MUX_PARITY_EN is defined.
module tdm_mux64_tx #(
   parameter int N_CH  = 64,
   parameter int SEL_W = 6,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out,
   output logic [SEL_W-1:0] sel_out,
   output logic             out_valid,
   output logic             frame_start,
   output logic             par_slot,
   output logic             busy
);

`ifdef TDM_MUX_PARITY_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR, S_GAP} state_t;
   localparam bit PAR_EN = 1'b1;
`else
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
   localparam bit PAR_EN = 1'b0;
`endif

   localparam logic [SEL_W-1:0] LAST     = SEL_W'(N_CH - 1);
   localparam logic [3:0]       GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

   state_t            r_state, w_state;
   logic [N_CH-1:0]   r_shift, w_shift;
   logic [SEL_W-1:0]  r_sel, w_sel;
   logic              r_out, w_out;
   logic              r_valid, w_valid;
   logic              r_fs, w_fs;
   logic              r_busy, w_busy;
   logic [3:0]        r_gap, w_gap;
   logic              r_live;
   logic              w_rdy_st;
   logic              w_accept;
   logic              w_end;
`ifdef TDM_MUX_PARITY_EN
   logic              r_parity, w_parity;
   logic              r_par, w_par;
`endif

   // in_ready is held low until the first clock after reset release
   always_comb begin
      w_rdy_st = 1'b0;
      unique case (r_state)
         S_IDLE:  w_rdy_st = 1'b1;
         S_SHIFT: w_rdy_st = !PAR_EN && (GAP == 0) && (r_sel == LAST);
`ifdef TDM_MUX_PARITY_EN
         S_PAR:   w_rdy_st = (GAP == 0);
`endif
         S_GAP:   w_rdy_st = (r_gap == GAP_LAST);
         default: w_rdy_st = 1'b0;
      endcase
   end

   assign in_ready = w_rdy_st && r_live;
   assign w_accept = in_valid && in_ready;

   always_comb begin
      w_state  = r_state;
      w_shift  = r_shift;
      w_sel    = r_sel;
      w_out    = r_out;
      w_valid  = r_valid;
      w_fs     = 1'b0;
      w_busy   = r_busy;
      w_gap    = r_gap;
      w_end    = 1'b0;
`ifdef TDM_MUX_PARITY_EN
      w_parity = r_parity;
      w_par    = 1'b0;
`endif
      if (w_accept) begin
         w_state = S_SHIFT;
         w_shift = in_data;
         w_sel   = '0;
         w_out   = in_data[0];
         w_valid = 1'b1;
         w_fs    = 1'b1;
         w_busy  = 1'b1;
`ifdef TDM_MUX_PARITY_EN
         w_parity = ^in_data;
`endif
      end else begin
         unique case (r_state)
            S_IDLE: begin
               w_valid = 1'b0;
               w_busy  = 1'b0;
            end
            S_SHIFT: begin
               if (r_sel != LAST) begin
                  w_shift = r_shift >> 1;
                  w_out   = r_shift[1];
                  w_sel   = r_sel + 1'b1;
               end else begin
`ifdef TDM_MUX_PARITY_EN
                  w_state = S_PAR;
                  w_out   = r_parity;
                  w_par   = 1'b1;
`else
                  w_end   = 1'b1;
`endif
               end
            end
`ifdef TDM_MUX_PARITY_EN
            S_PAR: w_end = 1'b1;
`endif
            S_GAP: begin
               if (r_gap == GAP_LAST) begin
                  w_state = S_IDLE;
                  w_busy  = 1'b0;
               end else begin
                  w_gap = r_gap + 4'd1;
               end
            end
            default: w_state = S_IDLE;
         endcase
      end
      // frame over with no new word waiting
      if (w_end) begin
         w_sel   = '0;
         w_out   = 1'b0;
         w_valid = 1'b0;
         w_gap   = 4'd0;
         if (GAP > 0) begin
            w_state = S_GAP;
            w_busy  = 1'b1;
         end else begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_shift  <= '0;
         r_sel    <= '0;
         r_out    <= 1'b0;
         r_valid  <= 1'b0;
         r_fs     <= 1'b0;
         r_busy   <= 1'b0;
         r_gap    <= 4'd0;
         r_live   <= 1'b0;
`ifdef TDM_MUX_PARITY_EN
         r_parity <= 1'b0;
         r_par    <= 1'b0;
`endif
      end else begin
         r_state  <= w_state;
         r_shift  <= w_shift;
         r_sel    <= w_sel;
         r_out    <= w_out;
         r_valid  <= w_valid;
         r_fs     <= w_fs;
         r_busy   <= w_busy;
         r_gap    <= w_gap;
         r_live   <= 1'b1;
`ifdef TDM_MUX_PARITY_EN
         r_parity <= w_parity;
         r_par    <= w_par;
`endif
      end
   end

   assign out         = r_out;
   assign sel_out     = r_sel;
   assign out_valid   = r_valid;
   assign frame_start = r_fs;
   assign busy        = r_busy;
`ifdef TDM_MUX_PARITY_EN
   assign par_slot    = r_par;
`else
   assign par_slot    = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_mux64_tx.sv
// Bench for tdm_mux64_tx: GAP=0 and GAP=3 instances against a slot-list model.
// Build with +define+TDM_MUX_PARITY_EN to cover the parity slot.
module tb_tdm_mux64_tx;

`ifdef TDM_MUX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   typedef struct packed {
      logic       v;
      logic [5:0] s;
      logic       o;
      logic       f;
      logic       p;
      logic       b;
      logic       r;
   } slot_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] din [2];
   logic [1:0]  vin, rdy, o, ov, fs, ps, bz;
   logic [5:0]  sel [2];
   int          checks = 0;
   int          errors = 0;
   logic [63:0] wq[$];
   slot_t       eq[$];

   always #5 clk = ~clk;

   tdm_mux64_tx #(.N_CH(64), .SEL_W(6), .GAP(0)) u_a (
      .clk(clk), .rst_n(rst_n), .in_data(din[0]), .in_valid(vin[0]),
      .in_ready(rdy[0]), .out(o[0]), .sel_out(sel[0]),
      .out_valid(ov[0]), .frame_start(fs[0]), .par_slot(ps[0]),
      .busy(bz[0])
   );

   tdm_mux64_tx #(.N_CH(64), .SEL_W(6), .GAP(3)) u_b (
      .clk(clk), .rst_n(rst_n), .in_data(din[1]), .in_valid(vin[1]),
      .in_ready(rdy[1]), .out(o[1]), .sel_out(sel[1]),
      .out_valid(ov[1]), .frame_start(fs[1]), .par_slot(ps[1]),
      .busy(bz[1])
   );

   function automatic slot_t obs(input int g);
      return {ov[g], sel[g], o[g], fs[g], ps[g], bz[g], rdy[g]};
   endfunction

   // Expected slot list: every frame's slots, optional parity slot,
   // the gap cycles, then two idle cycles.
   task automatic build(input int g);
      int    gp;
      slot_t e;
      gp = (g == 0) ? 0 : 3;
      eq.delete();
      foreach (wq[i]) begin
         for (int k = 0; k < 64; k++) begin
            e.v = 1'b1; e.s = 6'(k); e.o = wq[i][k];
            e.f = (k == 0); e.p = 1'b0; e.b = 1'b1;
            e.r = (gp == 0) && !PAR && (k == 63);
            eq.push_back(e);
         end
         if (PAR) begin
            e.v = 1'b1; e.s = 6'd63; e.o = ^wq[i];
            e.f = 1'b0; e.p = 1'b1; e.b = 1'b1; e.r = (gp == 0);
            eq.push_back(e);
         end
         for (int j = 0; j < gp; j++) begin
            e = '0; e.b = 1'b1; e.r = (j == gp - 1);
            eq.push_back(e);
         end
      end
      for (int j = 0; j < 2; j++) begin
         e = '0; e.r = 1'b1;
         eq.push_back(e);
      end
   endtask

   // Producer offers wq in order, holding valid until each handshake.
   task automatic run_stream(input int g, input bit zero_after,
                             input string nm);
      int    idx;
      bit    hs;
      slot_t got;
      build(g);
      idx = 0;
      din[g] = wq[0];
      vin[g] = 1'b1;
      #0;
      hs = vin[g] && rdy[g];
      checks++;
      if (!hs) begin
         errors++;
         $display("FAIL %s_start dut%0d in_ready got %b exp 1", nm, g, rdy[g]);
      end
      foreach (eq[n]) begin
         @(posedge clk); #1;
         if (hs) begin
            idx++;
            if (idx < wq.size()) begin
               din[g] = wq[idx];
            end else begin
               vin[g] = 1'b0;
               din[g] = zero_after ? 64'h0 : {$urandom, $urandom};
            end
         end else if (!vin[g] && !zero_after) begin
            din[g] = {$urandom, $urandom};
         end
         got = obs(g);
         checks++;
         if (got !== eq[n]) begin
            errors++;
            $display("FAIL %s dut%0d cyc%0d got v%b s%0d o%b f%b p%b b%b r%b exp v%b s%0d o%b f%b p%b b%b r%b",
                     nm, g, n, got.v, got.s, got.o, got.f, got.p, got.b,
                     got.r, eq[n].v, eq[n].s, eq[n].o, eq[n].f, eq[n].p,
                     eq[n].b, eq[n].r);
         end
         hs = vin[g] && rdy[g];
      end
      checks++;
      if (idx != wq.size()) begin
         errors++;
         $display("FAIL %s_count dut%0d accepted %0d exp %0d", nm, g, idx,
                  wq.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      vin = 2'b00;
      din[0] = 64'h0;
      din[1] = 64'h0;
      #1;
      for (int g = 0; g < 2; g++) begin
         checks++;
         if (obs(g) !== slot_t'(0)) begin
            errors++;
            $display("FAIL reset_out dut%0d got %h exp 0", g, obs(g));
         end
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      checks++;
      if (rdy !== 2'b00) begin
         errors++;
         $display("FAIL reset_ready_early got %b exp 00", rdy);
      end
      @(posedge clk); #1;
      checks++;
      if (rdy !== 2'b11) begin
         errors++;
         $display("FAIL reset_ready_after got %b exp 11", rdy);
      end
   endtask

   task automatic test_single();
      wq.delete();
      wq.push_back(64'h0000_0000_0000_0001);
      run_stream(0, 1'b0, "single");
   endtask

   task automatic test_back_to_back();
      wq.delete();
      wq.push_back(64'h8000_0000_0000_0001);
      wq.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      run_stream(0, 1'b0, "b2b");
   endtask

   task automatic test_gap();
      wq.delete();
      wq.push_back({$urandom, $urandom});
      wq.push_back({$urandom, $urandom});
      run_stream(1, 1'b0, "gap");
   endtask

   task automatic test_mid_change();
      wq.delete();
      wq.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      run_stream(0, 1'b1, "midchg");
   endtask

   task automatic test_random();
      for (int t = 0; t < 4; t++) begin
         wq.delete();
         for (int i = 0; i < int'($urandom_range(1, 3)); i++)
            wq.push_back({$urandom, $urandom});
         run_stream(t % 2, 1'b0, "rand");
      end
   endtask

   task automatic test_abort();
      slot_t e;
      int    nv;
      din[0] = 64'hAAAA_AAAA_AAAA_AAAA;
      vin[0] = 1'b1;
      @(posedge clk); #1;
      vin[0] = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
      end
      e = '0; e.v = 1'b1; e.s = 6'd20; e.o = 1'b0; e.b = 1'b1;
      checks++;
      if (obs(0) !== e) begin
         errors++;
         $display("FAIL abort_pre got %h exp %h", obs(0), e);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs(0) !== slot_t'(0)) begin
         errors++;
         $display("FAIL abort_reset got %h exp 0", obs(0));
      end
      #2 rst_n = 1'b1;
      nv = 0;
      repeat (70) begin
         @(posedge clk); #1;
         if (ov[0] || bz[0]) nv++;
      end
      checks++;
      if (nv != 0) begin
         errors++;
         $display("FAIL abort_after slots got %0d exp 0", nv);
      end
   endtask

   task automatic test_parity();
      wq.delete();
      wq.push_back(64'h0000_0000_0000_0007);
      run_stream(0, 1'b0, "par7");
      wq.delete();
      wq.push_back(64'h0000_0000_0000_0003);
      run_stream(0, 1'b0, "par3");
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_gap();
      test_mid_change();
      test_abort();
      test_random();
      if (PAR) test_parity();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tdm_mux64_tx.md
Name: tdm_mux64_tx

Overview:
- Time-division multiplexing transmitter, the send side of the 64-channel demux path.
- Captures one N_CH-bit parallel word through a valid/ready handshake.
- Then emits one channel bit per clock on a serial line, along with the channel index driving the far-end demuxer select.
- Sits between the parallel producer and the serial link feeding the demux receiver.

Parameters:
- N_CH, 64, number of channels per frame; must be a power of two, at least 2.
- SEL_W, 6, select/index width; must equal log2(N_CH).
- GAP, 0, idle cycles inserted between frames; range 0..15.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N_CH  parallel channel word; bit k is channel k.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block accepts in_data this cycle.
- out  output  1  serial channel bit.
- sel_out  output  SEL_W  index of the channel currently on out.
- out_valid  output  1  out/sel_out/par_slot carry a meaningful slot.
- frame_start  output  1  high on the slot where sel_out==0.
- par_slot  output  1  current slot is the parity slot (see Optional Feature).
- busy  output  1  frame in progress (SHIFT, PAR or GAP).

Behaviour:
- Reset (async assert, sync release): state=IDLE, shift register=0, out=0, sel_out=0, out_valid=0, frame_start=0, par_slot=0, busy=0, in_ready=0. in_ready goes to 1 on the first clock after release.
- All outputs are registered except in_ready, which is combinational from state and counter.
- States: IDLE, SHIFT, PAR (macro only), GAP.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data into the shift register and go to SHIFT.
  - The first slot (sel_out=0, out=in_data[0], out_valid=1, frame_start=1) appears the cycle after acceptance; latency is 1 clock.
- SHIFT:
  - Per cycle: out = word[sel_out], out_valid=1, frame_start = (sel_out==0).
  - sel_out increments by 1 modulo 2^SEL_W.
  - On the slot sel_out==N_CH-1, the next state is PAR if the macro is enabled, else GAP if GAP>0, else IDLE.
- Back-to-back frames (GAP=0, macro off):
  - in_ready is also 1 during the final slot (sel_out==N_CH-1).
  - A word accepted then starts its sel_out=0 slot on the very next cycle, giving a continuous stream with no bubble.
  - Otherwise in_ready=0 while busy.
- GAP:
  - Counts GAP cycles with out_valid=0, out=0, sel_out=0, frame_start=0.
  - in_ready=1 only on the last gap cycle, so the next frame starts immediately after the gap.
  - Otherwise returns to IDLE.
- Once accepted, in_data is ignored until the next acceptance. Changes in in_data mid-frame have no effect.
- in_valid deasserting mid-frame has no effect on the frame in flight.
- When in_valid is low at a ready point: the block goes to IDLE, out_valid=0, and sel_out holds 0.
- Reset asserted mid-frame: the frame is aborted immediately; no partial slots follow release.
- busy=1 exactly while out_valid=1 or in GAP.

Optional Feature:
- Macro: TDM_MUX_PARITY_EN.
- Defined:
  - After slot N_CH-1, one extra PAR slot is emitted: out = XOR of all N_CH captured bits, sel_out = N_CH-1 (held), par_slot=1, out_valid=1, frame_start=0.
  - The frame is N_CH+1 slots. The back-to-back in_ready window moves to the PAR slot.
- Undefined: no PAR state; par_slot is tied 0; the frame is N_CH slots.

Test Plan:
- Reset then single word 64'h0000_0000_0000_0001 -> slot sel 0 out=1 frame_start=1; sel 1..63 out=0; out_valid low after slot 63 (macro off).
- Word 64'h8000_0000_0000_0001 followed immediately by 64'hFFFF_FFFF_FFFF_FFFF, GAP=0 -> 128 consecutive out_valid cycles; second frame_start exactly 64 cycles after the first; second frame all ones.
- GAP=3, two words held valid -> exactly 3 out_valid=0 cycles between slot 63 and the next sel 0; in_ready high only on the third gap cycle.
- rst_n low at sel_out=20 of word 64'hAAAA_AAAA_AAAA_AAAA -> all outputs 0 asynchronously; after release, no slots until a new handshake.
- TDM_MUX_PARITY_EN with word 64'h0000_0000_0000_0007 -> 65th slot par_slot=1, out=1, sel_out=63; word 64'h3 -> parity slot out=0.
- in_data changed to 64'h0 mid-frame after accepting 64'hFFFF_FFFF_FFFF_FFFF -> remaining slots still out=1.
